// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and constants for the lc3 wait-state memory controller
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_RD_LAT = 2;
    localparam int DEF_WR_LAT = 2;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/lc3_mem_array.sv
// rtl/lc3_mem_array.sv - single-port sync-write/sync-read word array with clearable read register
module lc3_mem_array #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // The read register only moves on a read strobe so it holds the last read value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - fixed-latency memory controller for the lc3 core memory bus
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int WR_LAT = DEF_WR_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memEN,
    input  logic              memWE,
    input  logic [ADDR_W-1:0] memory_addr,
    input  logic [DATA_W-1:0] memory_din,
    output logic [DATA_W-1:0] memory_dout,
    output logic              memRDY,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data
);

    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              we_q, we_d;

    logic              commit;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_din;
    logic              c_we;

    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;

    // With a latency of 1 the commit happens on the acceptance edge, so the
    // commit path must see the live bus rather than the not-yet-loaded latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = we_q;
        commit  = 1'b0;
        c_addr  = addr_q;
        c_din   = din_q;
        c_we    = we_q;
        case (state_q)
            IDLE: begin
                if (memEN) begin
                    addr_d = memory_addr;
                    din_d  = memory_din;
                    we_d   = memWE;
                    c_addr = memory_addr;
                    c_din  = memory_din;
                    c_we   = memWE;
                    cnt_d  = memWE ? WR_CNT : RD_CNT;
                    if (cnt_d == '0) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
        end
    end

    // Reset owns the array port for preloading and suppresses any pending commit.
    assign arr_we    = rst ? init_we   : (commit & c_we);
    assign arr_re    = ~rst & commit & ~c_we;
    assign arr_addr  = rst ? init_addr : c_addr;
    assign arr_wdata = rst ? init_data : c_din;

    lc3_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (memory_dout)
    );

    assign memRDY = (state_q == DONE);

endmodule
